// File: rtl/count_run_sequencer.sv
// Run/pause/stop sequencer for a two-digit BCD counter. A synchronous prescaler
// produces one step every DIV_MAX+1 RUN cycles; digits count up or down and stop on stop_val.
module count_run_sequencer #(
  parameter int unsigned DIV_MAX = 25,
  parameter int unsigned DIV_W   = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       up_down,
  input  logic [7:0] stop_val,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       tick,
  output logic       carry,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] DIV_MAX_C = DIV_W'(DIV_MAX);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [3:0]       ones_q, ones_d;
  logic [3:0]       tens_q, tens_d;
  logic             tick_q, tick_d;
  logic             carry_q, carry_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic [8:0]       next_digits_s;
  logic             hit_s;

  // One BCD step on both nibbles; result is {wrap, tens, ones}, never leaving 0..9.
  function automatic logic [8:0] bcd_step(input logic [3:0] t, input logic [3:0] o,
                                          input logic up);
    logic [3:0] nt;
    logic [3:0] no;
    logic       wrap;
    nt   = t;
    no   = o;
    wrap = 1'b0;
    if (up) begin
      if (o >= 4'd9) begin
        no = 4'd0;
        if (t >= 4'd9) begin
          nt   = 4'd0;
          wrap = 1'b1;
        end else begin
          nt = t + 4'd1;
        end
      end else begin
        no = o + 4'd1;
      end
    end else begin
      if (o == 4'd0) begin
        no = 4'd9;
        if (t == 4'd0) begin
          nt   = 4'd9;
          wrap = 1'b1;
        end else begin
          nt = t - 4'd1;
        end
      end else begin
        no = o - 4'd1;
      end
    end
    return {wrap, nt, no};
  endfunction

  // A stop value with any non-decimal nibble never matches.
  function automatic logic stop_hit(input logic [7:0] digits, input logic [7:0] sv);
    return (sv[7:4] <= 4'd9) && (sv[3:0] <= 4'd9) && (digits == sv);
  endfunction

  assign next_digits_s = bcd_step(tens_q, ones_q, up_down);
  assign hit_s         = stop_hit(next_digits_s[7:0], stop_val);

  // Next-state, prescaler and digit update; clear overrides everything else.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
      ones_d  = 4'd0;
      tens_d  = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_d = '0;
          if (start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (presc_q == DIV_MAX_C) begin
            presc_d = '0;
            tens_d  = next_digits_s[7:4];
            ones_d  = next_digits_s[3:0];
            tick_d  = 1'b1;
            carry_d = next_digits_s[8];
            // A terminal match wins over a coincident pause.
            if (hit_s) begin
              state_d = ST_DONE;
            end else if (start) begin
              state_d = ST_RUN;
            end else if (pause) begin
              state_d = ST_PAUSE;
            end else begin
              state_d = ST_RUN;
            end
          end else if (start) begin
            presc_d = presc_q + DIV_W'(1);
          end else if (pause) begin
            state_d = ST_PAUSE;
            presc_d = presc_q;
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end
        ST_PAUSE: begin
          if (start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_DONE: begin
          presc_d = '0;
          if (start) begin
            state_d = ST_RUN;
            ones_d  = 4'd0;
            tens_d  = 4'd0;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          presc_d = '0;
        end
      endcase
    end
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      tick_q    <= 1'b0;
      carry_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      tick_q    <= tick_d;
      carry_q   <= carry_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign ones    = ones_q;
  assign tens    = tens_q;
  assign tick    = tick_q;
  assign carry   = carry_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_count_run_sequencer.sv
// Directed bench for count_run_sequencer with DIV_MAX=3: a vector table for the
// basic run-to-stop flow plus hand sequences for pause, clear, wrap, borrow and reset.
module tb_count_run_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, pause, clear, up_down;
  logic [7:0] stop_val;
  logic [3:0] ones, tens;
  logic       tick, carry, running, done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       s, p, c, ud;
    logic [7:0] sv;
    logic [7:0] dig;
    logic       t, ca, r, d;
  } vec_t;

  vec_t tbl [0:27];

  count_run_sequencer #(.DIV_MAX(3), .DIV_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
    .up_down(up_down), .stop_val(stop_val), .ones(ones), .tens(tens),
    .tick(tick), .carry(carry), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic p, input logic c, input logic ud,
                              input logic [7:0] sv, input logic [7:0] dig, input logic t,
                              input logic ca, input logic r, input logic d);
    vec_t v;
    v.s = s; v.p = p; v.c = c; v.ud = ud; v.sv = sv; v.dig = dig;
    v.t = t; v.ca = ca; v.r = r; v.d = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [7:0] dig, input logic t,
                         input logic ca, input logic r, input logic d);
    chk({name, " digits"}, {tens, ones}, dig);
    chk({name, " flags(tick,carry,run,done)"}, {4'h0, tick, carry, running, done},
        {4'h0, t, ca, r, d});
  endtask

  task automatic cyc(input logic s, input logic p, input logic c);
    start = s; pause = p; clear = c;
    @(posedge clk);
    #1;
    start = 1'b0; pause = 1'b0; clear = 1'b0;
  endtask

  int d;
  logic [7:0] e;

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0;
    up_down = 1'b1; stop_val = 8'h05;

    tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      for (int j = 1; j <= 4; j++) begin
        tbl[(k - 1) * 4 + j] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h05,
                                  (j == 4) ? 8'(k) : 8'(k - 1), (j == 4), 1'b0,
                                  !(k == 5 && j == 4), (k == 5 && j == 4));
      end
    end
    tbl[21] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[22] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[23] = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[24] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[25] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[26] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[27] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    chk_out("idle_after_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Run to stop value 05, hold in DONE, restart from DONE.
    for (int i = 0; i < 28; i++) begin
      up_down  = tbl[i].ud;
      stop_val = tbl[i].sv;
      cyc(tbl[i].s, tbl[i].p, tbl[i].c);
      chk_out($sformatf("vec%0d", i), tbl[i].dig, tbl[i].t, tbl[i].ca, tbl[i].r, tbl[i].d);
    end

    // Pause two cycles after a step, hold, resume: step lands two cycles later.
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk_out("pause_enter", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk_out("paused", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b0);
    chk_out("resume", 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk_out("resume_plus1", 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk_out("resume_step", 8'h02, 1'b1, 1'b0, 1'b1, 1'b0);

    // clear together with start on a step edge.
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk_out("pre_clear", 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    chk_out("clear_on_step", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk_out("clear_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Count up through 98, 99, 00 (carry), 01 ... 10 with the stop disabled.
    stop_val = 8'hFF;
    up_down  = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    chk_out("wrap_start", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= 110; n++) begin
      d = n % 100;
      e = {4'(d / 10), 4'(d % 10)};
      cyc(1'b0, 1'b0, 1'b0);
      chk("wrap_gap_flags", {4'h0, tick, carry, running, done}, 8'h02);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk_out($sformatf("up_step%0d", n), e, 1'b1, (n == 100), 1'b1, 1'b0);
    end

    // Direction change at 10: borrow to 09 without carry.
    up_down = 1'b0;
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    chk_out("down_borrow", 8'h09, 1'b1, 1'b0, 1'b1, 1'b0);

    // Down from 00 wraps to 99 with carry.
    cyc(1'b0, 1'b0, 1'b1);
    chk_out("clear2", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    chk_out("down_wrap", 8'h99, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    chk_out("down_98", 8'h98, 1'b1, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of RUN at 42.
    cyc(1'b0, 1'b0, 1'b1);
    up_down = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    for (int n = 1; n <= 42; n++) begin
      repeat (4) cyc(1'b0, 1'b0, 1'b0);
    end
    chk_out("at_42", 8'h42, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_out("async_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk_out("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
